// File: rtl/pid_loop_sequencer.sv
// Per-wheel speed-loop sequencer: tick, tach snapshot, PID step,
// control-to-PWM conversion and period-aligned duty commit.
module pid_loop_sequencer #(
    parameter int PV_WIDTH       = 8,
    parameter int CONTROL_WIDTH  = 18,
    parameter int PWM_RESOLUTION = 17,
    parameter int LOOP_DIV       = 125000,
    parameter int DIV_WIDTH      = 17,
    parameter int PID_LATENCY    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      clr_overrun,
    input  logic [PV_WIDTH-1:0]       tach_count,
    output logic                      tach_latch,
    output logic [PV_WIDTH-1:0]       pid_feedback,
    output logic                      pid_clk_en,
    output logic                      pid_en,
    input  logic [CONTROL_WIDTH-1:0]  pid_control,
    input  logic                      pwm_period_end,
    output logic [PWM_RESOLUTION-1:0] duty,
    output logic                      dir,
    output logic                      duty_update,
    output logic                      busy,
    output logic                      overrun
);

    localparam int WW = $clog2(PID_LATENCY + 1);
    localparam int MW = (CONTROL_WIDTH > PWM_RESOLUTION) ?
                        CONTROL_WIDTH : PWM_RESOLUTION;
    localparam logic [MW-1:0] DUTY_MAX = MW'({PWM_RESOLUTION{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_CAPTURE,
        S_STEP,
        S_WAIT,
        S_ARM
    } state_t;

    state_t                    state;
    state_t                    state_nx;
    logic [DIV_WIDTH-1:0]      div_q;
    logic [WW-1:0]             wait_q;
    logic                      div_wrap;
    logic                      tick;
    logic                      wait_last;
    logic                      commit;
    logic                      neg;
    logic [CONTROL_WIDTH-1:0]  mag;
    logic [MW-1:0]             mag_ext;
    logic [PWM_RESOLUTION-1:0] duty_conv;
    logic [PWM_RESOLUTION-1:0] pend_duty;
    logic                      pend_dir;

    assign div_wrap  = (div_q == DIV_WIDTH'(LOOP_DIV - 1));
    assign tick      = en & div_wrap;
    assign wait_last = (state == S_WAIT) && (wait_q == WW'(1));
    assign commit    = en && (state == S_ARM) && pwm_period_end;

    // Most-negative input yields 2^(CW-1) unsigned, which then saturates.
    assign neg       = pid_control[CONTROL_WIDTH-1];
    assign mag       = neg ? (~pid_control + CONTROL_WIDTH'(1)) : pid_control;
    assign mag_ext   = MW'(mag);
    assign duty_conv = (mag_ext > DUTY_MAX) ? '1 : mag_ext[PWM_RESOLUTION-1:0];

    assign tach_latch = (state == S_LATCH);
    assign pid_clk_en = (state == S_STEP);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (tick) state_nx = S_LATCH;
            S_LATCH:   state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_STEP;
            S_STEP:    state_nx = S_WAIT;
            S_WAIT:    if (wait_q == WW'(1)) state_nx = S_ARM;
            S_ARM:     if (pwm_period_end) state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
        if (!en) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q        <= '0;
            wait_q       <= '0;
            pid_en       <= 1'b0;
            pid_feedback <= '0;
            pend_duty    <= '0;
            pend_dir     <= 1'b0;
            duty         <= '0;
            dir          <= 1'b0;
            duty_update  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            pid_en <= en;
            if (!en) begin
                div_q       <= '0;
                duty        <= '0;
                dir         <= 1'b0;
                duty_update <= (|duty) | dir;
            end else begin
                div_q       <= div_wrap ? '0 : div_q + DIV_WIDTH'(1);
                duty_update <= commit;
                if (commit) begin
                    duty <= pend_duty;
                    dir  <= pend_dir;
                end
            end
            if (en && state == S_CAPTURE) pid_feedback <= tach_count;
            if (state == S_STEP) begin
                wait_q <= WW'(PID_LATENCY);
            end else if (state == S_WAIT) begin
                wait_q <= wait_q - WW'(1);
            end
            if (en && wait_last) begin
                pend_duty <= duty_conv;
                pend_dir  <= neg;
            end
            // A dropped tick outranks a same-cycle clear.
            if (tick && state != S_IDLE) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Directed bench for pid_loop_sequencer with LOOP_DIV=10, PID_LATENCY=2.
// Cycle k of a loop is the cycle whose outputs are sampled at negedge k.
module tb_pid_loop_sequencer;

    logic        clk;
    logic        reset;
    logic        en;
    logic        clr_overrun;
    logic [7:0]  tach_count;
    logic        tach_latch;
    logic [7:0]  pid_feedback;
    logic        pid_clk_en;
    logic        pid_en;
    logic [17:0] pid_control;
    logic        pwm_period_end;
    logic [16:0] duty;
    logic        dir;
    logic        duty_update;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    pid_loop_sequencer #(
        .PV_WIDTH(8),
        .CONTROL_WIDTH(18),
        .PWM_RESOLUTION(17),
        .LOOP_DIV(10),
        .DIV_WIDTH(4),
        .PID_LATENCY(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .clr_overrun(clr_overrun),
        .tach_count(tach_count),
        .tach_latch(tach_latch),
        .pid_feedback(pid_feedback),
        .pid_clk_en(pid_clk_en),
        .pid_en(pid_en),
        .pid_control(pid_control),
        .pwm_period_end(pwm_period_end),
        .duty(duty),
        .dir(dir),
        .duty_update(duty_update),
        .busy(busy),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic restart();
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        en = 1'b0;
        clr_overrun = 1'b0;
        tach_count = 8'd14;
        pid_control = 18'd0;
        pwm_period_end = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({tach_latch, pid_feedback, pid_clk_en, pid_en, duty, dir,
             duty_update, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got tl=%0b fb=%0d ce=%0b pe=%0b d=%0d dir=%0b du=%0b b=%0b ov=%0b, want all 0",
                     tach_latch, pid_feedback, pid_clk_en, pid_en, duty,
                     dir, duty_update, busy, overrun);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_loop();
        logic       e_tl, e_ce, e_b, e_du;
        logic [16:0] e_d;
        tach_count = 8'd14;
        pid_control = 18'd300;
        pwm_period_end = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            en = 1'b1;
            e_tl = (k == 10) || (k == 20);
            e_ce = (k == 12);
            e_b  = (k >= 10 && k <= 15) || (k == 20);
            e_du = (k == 16);
            e_d  = (k >= 16) ? 17'd300 : 17'd0;
            checks++;
            if (tach_latch !== e_tl) begin
                errors++;
                $display("FAIL loop_tach_latch k=%0d: got %0b want %0b", k, tach_latch, e_tl);
            end
            checks++;
            if (pid_clk_en !== e_ce) begin
                errors++;
                $display("FAIL loop_pid_clk_en k=%0d: got %0b want %0b", k, pid_clk_en, e_ce);
            end
            checks++;
            if (busy !== e_b) begin
                errors++;
                $display("FAIL loop_busy k=%0d: got %0b want %0b", k, busy, e_b);
            end
            checks++;
            if (duty_update !== e_du || duty !== e_d || dir !== 1'b0) begin
                errors++;
                $display("FAIL loop_duty k=%0d: got d=%0d dir=%0b du=%0b want d=%0d dir=0 du=%0b",
                         k, duty, dir, duty_update, e_d, e_du);
            end
            checks++;
            if (pid_en !== (k >= 1)) begin
                errors++;
                $display("FAIL loop_pid_en k=%0d: got %0b want %0b", k, pid_en, k >= 1);
            end
            if (k == 11 || k == 12) begin
                checks++;
                if (pid_feedback !== ((k == 12) ? 8'd14 : 8'd0)) begin
                    errors++;
                    $display("FAIL loop_feedback k=%0d: got %0d", k, pid_feedback);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_conversion();
        int          vals[4]   = '{-5, 131071, -131072, 0};
        logic [16:0] e_duty[4] = '{17'd5, 17'd131071, 17'd131071, 17'd0};
        logic        e_dir[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        pwm_period_end = 1'b1;
        for (int v = 0; v < 4; v++) begin
            restart();
            pid_control = 18'(vals[v]);
            for (int k = 0; k <= 16; k++) begin
                en = 1'b1;
                @(negedge clk);
            end
            checks++;
            if (duty !== e_duty[v] || dir !== e_dir[v]) begin
                errors++;
                $display("FAIL conv_%0d: got duty=%0d dir=%0b want duty=%0d dir=%0b",
                         vals[v], duty, dir, e_duty[v], e_dir[v]);
            end
        end
    endtask

    task automatic test_overrun();
        restart();
        pid_control = 18'd300;
        for (int k = 0; k <= 50; k++) begin
            en = 1'b1;
            pwm_period_end = (k == 30);
            clr_overrun = (k == 32) || (k == 49);
            if (k == 19 || k == 20 || k == 31 || k == 33 || k == 50) begin
                checks++;
                if (overrun !== (k != 19 && k != 33)) begin
                    errors++;
                    $display("FAIL overrun k=%0d: got %0b want %0b", k, overrun, k != 19 && k != 33);
                end
            end
            if (k == 20) begin
                checks++;
                if (busy !== 1'b1 || tach_latch !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_drop: got busy=%0b tl=%0b want 1 0", busy, tach_latch);
                end
            end
            if (k == 30) begin
                checks++;
                if (duty !== 17'd0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_hold: got duty=%0d busy=%0b want 0 1", duty, busy);
                end
            end
            if (k == 31) begin
                checks++;
                if (duty !== 17'd300 || duty_update !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_commit: got duty=%0d du=%0b busy=%0b want 300 1 0",
                             duty, duty_update, busy);
                end
            end
            if (k == 40) begin
                checks++;
                if (tach_latch !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_next_latch: got %0b want 1", tach_latch);
                end
            end
            @(negedge clk);
        end
        pwm_period_end = 1'b1;
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL ovr_final_clear: got %0b want 0", overrun);
        end
    endtask

    task automatic test_en_drop();
        restart();
        pid_control = 18'd300;
        pwm_period_end = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            en = !(k >= 23 && k < 30);
            if (k == 16 || k == 23) begin
                checks++;
                if (duty !== 17'd300 || (k == 23 && busy !== 1'b1)) begin
                    errors++;
                    $display("FAIL drop_pre k=%0d: got duty=%0d busy=%0b", k, duty, busy);
                end
            end
            if (k == 24) begin
                checks++;
                if (busy !== 1'b0 || pid_en !== 1'b0 || duty !== 17'd0 ||
                    dir !== 1'b0 || duty_update !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_now: got b=%0b pe=%0b d=%0d dir=%0b du=%0b want 0 0 0 0 1",
                             busy, pid_en, duty, dir, duty_update);
                end
            end
            if (k == 25) begin
                checks++;
                if (duty_update !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_single_update: got %0b want 0", duty_update);
                end
            end
            if (k >= 24 && k <= 39) begin
                checks++;
                if (pid_clk_en !== 1'b0 || tach_latch !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_quiet k=%0d: got ce=%0b tl=%0b want 0 0",
                             k, pid_clk_en, tach_latch);
                end
            end
            if (k == 40) begin
                checks++;
                if (tach_latch !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_relatch: got %0b want 1", tach_latch);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        restart();
        pid_control = 18'd300;
        for (int k = 0; k <= 30; k++) begin
            en = 1'b1;
            pwm_period_end = (k < 16);
            @(negedge clk);
        end
        checks++;
        if (overrun !== 1'b1 || duty !== 17'd300 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arst_setup: got ov=%0b duty=%0d busy=%0b want 1 300 1",
                     overrun, duty, busy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({tach_latch, pid_feedback, pid_clk_en, pid_en, duty, dir,
             duty_update, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL arst_outputs: got tl=%0b fb=%0d ce=%0b pe=%0b d=%0d dir=%0b du=%0b b=%0b ov=%0b, want all 0",
                     tach_latch, pid_feedback, pid_clk_en, pid_en, duty,
                     dir, duty_update, busy, overrun);
        end
        @(negedge clk);
        pwm_period_end = 1'b1;
        reset = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            en = 1'b1;
            checks++;
            if (tach_latch !== (k == 10) || pid_clk_en !== (k == 12)) begin
                errors++;
                $display("FAIL arst_rerun k=%0d: got tl=%0b ce=%0b", k, tach_latch, pid_clk_en);
            end
            if (k == 12) begin
                checks++;
                if (pid_feedback !== 8'd14) begin
                    errors++;
                    $display("FAIL arst_feedback: got %0d want 14", pid_feedback);
                end
            end
            if (k == 16) begin
                checks++;
                if (duty !== 17'd300 || duty_update !== 1'b1) begin
                    errors++;
                    $display("FAIL arst_commit: got duty=%0d du=%0b want 300 1",
                             duty, duty_update);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_first_loop();
        test_conversion();
        test_overrun();
        test_en_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
